// File: rtl/fetch_pkg.sv
// Shared types and sizes for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned FETCH_BUF_DEPTH = 2;
  localparam int unsigned INSTR_W         = 32;
  localparam int unsigned PC_W            = 32;
  localparam int unsigned CNT_W           = $clog2(FETCH_BUF_DEPTH + 1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry synchronous buffer of fetched {instr, pc} pairs; head is slot0.
// Flush beats push; the head holds its value while nothing is popped.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  fetch_entry_t       push_data_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output fetch_entry_t       head_o,
  output logic               valid_o,
  output logic [CNT_W-1:0]   count_o
);

  fetch_entry_t     slot0_q, slot0_d;
  fetch_entry_t     slot1_q, slot1_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] wr_idx;
  logic             valid_q, valid_d;
  logic             do_pop;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    do_pop  = pop_i && (count_q != '0);
    wr_idx  = count_q - CNT_W'(do_pop);
    if (flush_i) begin
      count_d = '0;
    end else begin
      // Shift only when a second entry exists, so a drained head stays put.
      if (do_pop && (count_q == CNT_W'(FETCH_BUF_DEPTH))) begin
        slot0_d = slot1_q;
      end
      if (push_i) begin
        if (wr_idx == '0) begin
          slot0_d = push_data_i;
        end else begin
          slot1_d = push_data_i;
        end
      end
      count_d = count_q - CNT_W'(do_pop) + CNT_W'(push_i);
    end
    valid_d = (count_d != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      overflow_a: assert (!(push_i && !do_pop && (count_q == CNT_W'(FETCH_BUF_DEPTH))));
    end
  end

  assign head_o  = slot0_q;
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, issues reads to a 1-cycle-latency RAM and
// buffers returned words for decode; redirects flush everything in flight.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR      = 32'h0000_0000,
  parameter int unsigned MEM_ADDR_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic [31:0]               mem_rdata,
  output logic [INSTR_W-1:0]        instr,
  output logic [PC_W-1:0]           instr_pc,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  input  logic                      jmp_valid,
  input  logic [31:0]               jmp_addr
);

  localparam int unsigned OCC_W = CNT_W + 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             pend_q, pend_d;
  logic [PC_W-1:0]  pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] count;
  logic [OCC_W-1:0] occ;
  logic [PC_W-1:0]  jmp_tgt;
  logic             pop, issue, push;
  fetch_entry_t     push_data, head;

  assign pop     = instr_valid && instr_ready;
  assign occ     = OCC_W'(count) + OCC_W'(pend_q);
  assign issue   = !jmp_valid && (occ < (OCC_W'(FETCH_BUF_DEPTH) + OCC_W'(pop)));
  assign jmp_tgt = jmp_addr & ~32'h3;

  // A returning word is only kept if no redirect lands this cycle.
  assign push            = pend_q && !jmp_valid;
  assign push_data.instr = mem_rdata;
  assign push_data.pc    = pend_pc_q;

  always_comb begin
    pc_d      = pc_q;
    pend_d    = 1'b0;
    pend_pc_d = pend_pc_q;
    if (jmp_valid) begin
      pc_d = jmp_tgt;
    end else if (issue) begin
      pend_d    = 1'b1;
      pend_pc_d = pc_q;
      pc_d      = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= BOOT_ADDR;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  fetch_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .flush_i     (jmp_valid),
    .head_o      (head),
    .valid_o     (instr_valid),
    .count_o     (count)
  );

  assign mem_addr = pc_q[MEM_ADDR_WIDTH-1:0];
  assign instr    = head.instr;
  assign instr_pc = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the fetch stream.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int unsigned AW     = 6;
  localparam logic [31:0] BOOT   = 32'h0000_0000;
  localparam logic [31:0] BOOT_W = 32'h0000_003C;

  logic          clk, rst;
  logic [AW-1:0] mem_addr, mem_addr_w;
  logic [31:0]   mem_rdata, mem_rdata_w;
  logic [31:0]   instr, instr_pc, instr_w, instr_pc_w;
  logic          instr_valid, instr_valid_w;
  logic          instr_ready, jmp_valid;
  logic [31:0]   jmp_addr;
  logic          ready_w, jv_w;
  logic [31:0]   ja_w;

  logic [31:0]   ram [16];
  int            n_cmp, n_bad;

  bit            m_init;
  logic [31:0]   m_pc, m_pend_pc;
  bit            m_pend;
  fetch_entry_t  m_q[$];

  instr_fetch #(.BOOT_ADDR(BOOT), .MEM_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jmp_valid(jmp_valid), .jmp_addr(jmp_addr)
  );

  instr_fetch #(.BOOT_ADDR(BOOT_W), .MEM_ADDR_WIDTH(AW)) dut_w (
    .clk(clk), .rst(rst), .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(ready_w), .jmp_valid(jv_w), .jmp_addr(ja_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read RAM models, one per DUT, sharing contents.
  always @(posedge clk) begin
    mem_rdata   <= ram[4'(mem_addr >> 2)];
    mem_rdata_w <= ram[4'(mem_addr_w >> 2)];
  end

  function automatic logic [31:0] ram_at(input logic [31:0] a);
    return ram[4'(a >> 2)];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_model();
    chk("m_valid", 32'(instr_valid), 32'(m_q.size() > 0));
    chk("m_addr", 32'(mem_addr), 32'(m_pc[AW-1:0]));
    if (m_q.size() > 0) begin
      chk("m_instr", instr, m_q[0].instr);
      chk("m_pc", instr_pc, m_q[0].pc);
    end
  endtask

  // Advance the reference stream by one clock edge given this cycle's inputs.
  task automatic model_step(input logic r, input logic rdy, input logic jv, input logic [31:0] ja);
    int           cnt;
    int           popn;
    bit           iss;
    fetch_entry_t e;
    if (r) begin
      m_init    = 1'b1;
      m_pc      = BOOT;
      m_pend    = 1'b0;
      m_pend_pc = '0;
      m_q.delete();
    end else if (m_init) begin
      cnt  = m_q.size();
      popn = (cnt > 0 && rdy) ? 1 : 0;
      iss  = !jv && ((cnt + int'(m_pend) - popn) < 2);
      if (popn == 1) void'(m_q.pop_front());
      if (jv) begin
        m_q.delete();
        m_pend = 1'b0;
        m_pc   = ja & 32'hFFFF_FFFC;
      end else begin
        if (m_pend) begin
          e.instr = ram_at(m_pend_pc);
          e.pc    = m_pend_pc;
          m_q.push_back(e);
        end
        if (iss) begin
          m_pend_pc = m_pc;
          m_pc      = m_pc + 32'd4;
        end
        m_pend = iss;
      end
    end
  endtask

  task automatic cyc(input logic r, input logic rdy, input logic jv, input logic [31:0] ja);
    rst         = r;
    instr_ready = rdy;
    jmp_valid   = jv;
    jmp_addr    = ja;
    if (m_init) compare_model();
    @(posedge clk);
    model_step(r, rdy, jv, ja);
    @(negedge clk);
  endtask

  task automatic chk_head(input string tag, input logic [31:0] ei, input logic [31:0] ep);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
    chk({tag, "_instr"}, instr, ei);
    chk({tag, "_pc"}, instr_pc, ep);
  endtask

  initial begin
    logic       r, rdy, jv;
    logic [31:0] ja;
    n_cmp = 0;
    n_bad = 0;
    m_init = 1'b0;
    for (int i = 0; i < 16; i++) ram[i] = 32'h11 * 32'(i + 1);
    rst = 1'b1; instr_ready = 1'b0; jmp_valid = 1'b0; jmp_addr = '0;
    ready_w = 1'b1; jv_w = 1'b0; ja_w = '0;
    @(negedge clk);

    // Reset / boot timing, plus the wrapping-boot instance.
    cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", instr_pc, 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("w_rst_addr", 32'(mem_addr_w), 32'h3C);
    cyc(0, 1, 0, 0);
    chk("boot_c1_valid", 32'(instr_valid), 32'd0);
    chk("boot_c1_addr", 32'(mem_addr), 32'd4);
    chk("w_c1_addr", 32'(mem_addr_w), 32'h00);
    cyc(0, 1, 0, 0);
    chk_head("boot_c2", 32'h11, 32'h0);
    chk("w_c2_valid", 32'(instr_valid_w), 32'd1);
    chk("w_c2_pc", instr_pc_w, 32'h3C);
    chk("w_c2_instr", instr_w, ram_at(32'h3C));
    cyc(0, 1, 0, 0);
    chk_head("boot_c3", 32'h22, 32'h4);
    chk("w_c3_pc", instr_pc_w, 32'h40);
    chk("w_c3_instr", instr_w, 32'h11);
    cyc(0, 1, 0, 0);
    chk_head("boot_c4", 32'h33, 32'h8);
    cyc(0, 1, 0, 0);
    chk_head("boot_c5", 32'h44, 32'hC);

    // Back-pressure for 5 cycles after the first valid word.
    cyc(1, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk_head("bp_hold", 32'h11, 32'h0);
    chk("bp_addr", 32'(mem_addr), 32'd8);
    cyc(0, 1, 0, 0);
    chk_head("bp_rel1", 32'h22, 32'h4);
    cyc(0, 1, 0, 0);
    chk_head("bp_rel2", 32'h33, 32'h8);

    // Redirect in cycle 6 of streaming.
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 32'h20);
    chk("jmp_c7_addr", 32'(mem_addr), 32'h20);
    chk("jmp_c7_valid", 32'(instr_valid), 32'd0);
    cyc(0, 1, 0, 0);
    chk("jmp_c8_valid", 32'(instr_valid), 32'd0);
    cyc(0, 1, 0, 0);
    chk_head("jmp_c9", ram_at(32'h20), 32'h20);

    // Redirect with simultaneous pop while the buffer is full; unaligned target.
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0);
    chk_head("jp_full", 32'h11, 32'h0);
    cyc(0, 1, 1, 32'h23);
    chk("jp_addr", 32'(mem_addr), 32'h20);
    chk("jp_v1", 32'(instr_valid), 32'd0);
    cyc(0, 1, 0, 0);
    chk("jp_v2", 32'(instr_valid), 32'd0);
    cyc(0, 1, 0, 0);
    chk_head("jp_tgt", ram_at(32'h20), 32'h20);

    // Address wrap inside the RAM while the PC keeps counting.
    cyc(0, 1, 1, 32'h3C);
    chk("wrap_a0", 32'(mem_addr), 32'h3C);
    cyc(0, 1, 0, 0);
    chk("wrap_a1", 32'(mem_addr), 32'h00);
    cyc(0, 1, 0, 0);
    chk_head("wrap_h0", ram_at(32'h3C), 32'h3C);
    cyc(0, 1, 0, 0);
    chk_head("wrap_h1", ram_at(32'h0), 32'h40);

    // Mid-stream reset with words buffered and a read in flight.
    cyc(1, 1, 0, 0); cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("mr_valid", 32'(instr_valid), 32'd0);
    chk("mr_instr", instr, 32'd0);
    chk("mr_pc", instr_pc, 32'd0);
    chk("mr_addr", 32'(mem_addr), 32'd0);
    cyc(0, 1, 0, 0);
    chk("mr_c1_valid", 32'(instr_valid), 32'd0);
    chk("mr_c1_addr", 32'(mem_addr), 32'd4);
    cyc(0, 1, 0, 0);
    chk_head("mr_c2", 32'h11, 32'h0);
    cyc(0, 1, 0, 0);
    chk_head("mr_c3", 32'h22, 32'h4);

    // Random traffic: stalls, redirects (incl. back-to-back) and resets.
    for (int i = 0; i < 600; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      jv  = ($urandom_range(0, 9) == 0);
      ja  = $urandom();
      if ($urandom_range(0, 1) == 1) ja = ja & 32'h3F;
      cyc(r, rdy, jv, ja);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
